// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache memory arbiter
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } arb_state_t;

  localparam int              CNT_W       = 4;
  localparam logic [CNT_W-1:0] BLOCK_WORDS = 4'd8;
  localparam logic [15:0]     BLOCK_MASK  = 16'hFFF0;
  localparam int              MEM_LAT     = 4;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - saturating 0..BLOCK_WORDS word counter for one block fill
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up to BLOCK_WORDS and hold there; never wraps inside a fill
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < BLOCK_WORDS)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - arbitrates I/D cache fills and D write-through onto one memory port
module cache_mem_arbiter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        busy
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [15:0]      r_base;
  logic [CNT_W-1:0] w_issue_cnt;
  logic [CNT_W-1:0] w_recv_cnt;
  logic             w_fill;
  logic             w_idle;
  logic             w_last;

  assign w_idle = (r_state == IDLE);
  assign w_fill = (r_state == FILL_I) || (r_state == FILL_D);
  // The 8th returning word closes the fill
  assign w_last = w_fill && mem_valid && (w_recv_cnt == (BLOCK_WORDS - 4'd1));

  // Counters are held clear while idle so every grant starts from zero
  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_idle),
    .i_inc (w_fill),
    .o_cnt (w_issue_cnt)
  );

  fill_counter u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_idle),
    .i_inc (w_fill && mem_valid),
    .o_cnt (w_recv_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the granted block base once; the requester may move its address afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
    end else if (w_idle && !d_wr_req) begin
      if (d_miss) begin
        r_base <= d_miss_addr & BLOCK_MASK;
      end else if (i_miss) begin
        r_base <= i_miss_addr & BLOCK_MASK;
      end
    end
  end

  // Next state: fixed priority grant from IDLE, no preemption elsewhere
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (d_wr_req)    w_next = WRITE;
        else if (d_miss) w_next = FILL_D;
        else if (i_miss) w_next = FILL_I;
      end
      FILL_I, FILL_D: begin
        if (w_last) w_next = IDLE;
      end
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: memory strobes, fill write enables and completion pulses
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    case (r_state)
      FILL_I, FILL_D: begin
        if (w_issue_cnt < BLOCK_WORDS) begin
          mem_en   = 1'b1;
          mem_addr = r_base + {11'd0, w_issue_cnt, 1'b0};
        end
        fill_word = w_recv_cnt[2:0];
        if (r_state == FILL_I) begin
          i_fill_we   = mem_valid;
          i_fill_done = w_last;
        end else begin
          d_fill_we   = mem_valid;
          d_fill_done = w_last;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy      = !w_idle;
  assign fill_data = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_ack;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .fill_data   (fill_data),
    .fill_word   (fill_word),
    .i_fill_we   (i_fill_we),
    .d_fill_we   (d_fill_we),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  // 4-cycle pipelined memory: a read issued in cycle c returns addr^5A5A in cycle c+4
  logic [3:0]  r_pv = '0;
  logic [15:0] r_pd0 = '0;
  logic [15:0] r_pd1 = '0;
  logic [15:0] r_pd2 = '0;
  logic [15:0] r_pd3 = '0;
  logic        r_spur = 1'b0;

  always @(posedge clk) begin
    r_pv  <= {r_pv[2:0], mem_en & ~mem_wr};
    r_pd0 <= mem_addr ^ 16'h5A5A;
    r_pd1 <= r_pd0;
    r_pd2 <= r_pd1;
    r_pd3 <= r_pd2;
  end

  assign mem_valid = r_pv[3] | r_spur;
  assign mem_rdata = r_pd3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first cycle after the grant edge; leaves in the cycle after done
  task automatic run_fill(input bit is_d, input logic [15:0] base, input int raise_d_at);
    logic [15:0] ea;
    logic [15:0] ed;
    for (int k = 0; k < 12; k++) begin
      ea = (k < 8) ? base + 16'(2 * k) : 16'h0000;
      check("fill_busy",   busy,   1);
      check("fill_mem_en", mem_en, (k < 8) ? 1 : 0);
      check("fill_mem_wr", mem_wr, 0);
      check("fill_addr",   mem_addr, ea);
      check("fill_wdata",  mem_wdata, 0);
      check("fill_we",       is_d ? d_fill_we : i_fill_we, (k >= 4) ? 1 : 0);
      check("fill_other_we", is_d ? i_fill_we : d_fill_we, 0);
      check("fill_done",       is_d ? d_fill_done : i_fill_done, (k == 11) ? 1 : 0);
      check("fill_other_done", is_d ? i_fill_done : d_fill_done, 0);
      if (k >= 4) begin
        ed = (base + 16'(2 * (k - 4))) ^ 16'h5A5A;
        check("fill_word", fill_word, k - 4);
        check("fill_data", fill_data, ed);
      end
      if (k == 2) begin
        if (is_d) d_miss_addr = 16'hBEEF;
        else      i_miss_addr = 16'hBEEF;
      end
      if (k == raise_d_at) begin
        d_miss      = 1'b1;
        d_miss_addr = 16'h4567;
      end
      if (k == 11) begin
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_miss = 1'b0; i_miss_addr = '0;
    d_miss = 1'b0; d_miss_addr = '0;
    d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;
    step();
    step();
    check("rst_busy",   busy,   0);
    check("rst_mem_en", mem_en, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_i_we",   i_fill_we, 0);
    check("rst_d_we",   d_fill_we, 0);
    check("rst_ack",    d_wr_ack, 0);
    rst = 1'b0;
    step();

    // Spurious mem_valid while idle
    r_spur = 1'b1;
    step();
    check("spur_i_we",   i_fill_we, 0);
    check("spur_d_we",   d_fill_we, 0);
    check("spur_i_done", i_fill_done, 0);
    check("spur_d_done", d_fill_done, 0);
    check("spur_word",   fill_word, 0);
    check("spur_busy",   busy, 0);
    r_spur = 1'b0;
    step();

    // Single I-cache fill of 0x1234
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    step();
    run_fill(1'b0, 16'h1230, -1);
    check("i_fill_idle", busy, 0);

    // All three requests together: WRITE, then FILL_D, then FILL_I
    d_wr_req = 1'b1; d_wr_addr = 16'h2222; d_wr_data = 16'hCAFE;
    d_miss = 1'b1;   d_miss_addr = 16'h3456;
    i_miss = 1'b1;   i_miss_addr = 16'h789A;
    step();
    check("wr_busy",  busy, 1);
    check("wr_en",    mem_en, 1);
    check("wr_wr",    mem_wr, 1);
    check("wr_addr",  mem_addr, 16'h2222);
    check("wr_wdata", mem_wdata, 16'hCAFE);
    check("wr_ack",   d_wr_ack, 1);
    d_wr_req = 1'b0;
    step();
    check("wr_ack_pulse", d_wr_ack, 0);
    check("wr_idle",      busy, 0);
    check("wr_idle_en",   mem_en, 0);
    check("wr_idle_wr",   mem_wr, 0);
    step();
    run_fill(1'b1, 16'h3450, -1);
    check("d_fill_idle", busy, 0);
    step();
    run_fill(1'b0, 16'h7890, -1);
    check("i_fill2_idle", busy, 0);

    // d_miss arriving in fill cycle 3 waits for the I fill to finish
    i_miss = 1'b1; i_miss_addr = 16'h0A10;
    step();
    run_fill(1'b0, 16'h0A10, 2);
    check("wait_idle", busy, 0);
    step();
    run_fill(1'b1, 16'h4560, -1);
    check("wait_d_idle", busy, 0);

    // Reset in fill cycle 6 abandons the fill
    i_miss = 1'b1; i_miss_addr = 16'h0800;
    step();
    for (int k = 0; k < 6; k++) begin
      check("rf_en",   mem_en, 1);
      check("rf_addr", mem_addr, 16'h0800 + 16'(2 * k));
      check("rf_we",   i_fill_we, (k >= 4) ? 1 : 0);
      if (k == 5) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    i_miss = 1'b0;
    check("rf_busy", busy, 0);
    check("rf_en0",  mem_en, 0);
    check("rf_addr0", mem_addr, 0);
    for (int j = 0; j < 6; j++) begin
      check("rf_late_we",   i_fill_we, 0);
      check("rf_late_done", i_fill_done, 0);
      check("rf_late_word", fill_word, 0);
      check("rf_late_busy", busy, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: i_miss  input  1  I-cache miss, level, held until i_fill_done.
REQ-004 SHALL have port: i_miss_addr  input  16  I-cache miss byte address.
REQ-005 SHALL have port: d_miss  input  1  D-cache miss, level, held until d_fill_done.
REQ-006 SHALL have port: d_miss_addr  input  16  D-cache miss byte address.
REQ-007 SHALL have port: d_wr_req  input  1  D-cache write-through request, level, held until d_wr_ack.
REQ-008 SHALL have ports: d_wr_addr  input  16  write address; d_wr_data  input  16  write data.
REQ-009 SHALL have ports: mem_en  output  1  memory access strobe; mem_wr  output  1  write when 1; mem_addr  output  16  address; mem_wdata  output  16  write data.
REQ-010 SHALL have ports: mem_rdata  input  16  read data; mem_valid  input  1  read data valid (fixed 4-cycle pipelined memory).
REQ-011 SHALL have ports: fill_data  output  16  equal to mem_rdata; fill_word  output  3  word index in block.
REQ-012 SHALL have ports: i_fill_we  output  1; d_fill_we  output  1  per-cache fill write enables.
REQ-013 SHALL have ports: i_fill_done, d_fill_done, d_wr_ack  output  1 each  one-cycle completion pulses; busy  output  1  state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FILL_I, FILL_D, WRITE.
REQ-015 In IDLE SHALL grant by fixed priority d_wr_req > d_miss > i_miss, entering WRITE/FILL_D/FILL_I on the next edge; no request -> stay IDLE.
REQ-016 SHALL latch granted block base = addr & 16'hFFF0 at grant; later address changes ignored until done.
REQ-017 In FILL_x SHALL issue 8 reads on 8 consecutive cycles: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, issue_cnt 0..7; mem_en=0 once 8 issued.
REQ-018 In FILL_x SHALL assert x_fill_we = mem_valid, with fill_word = recv_cnt; recv_cnt increments on each mem_valid.
REQ-019 SHALL pulse x_fill_done in the cycle of the 8th mem_valid (with its fill_we), then return to IDLE.
REQ-020 WRITE SHALL last one cycle: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1; then IDLE.
REQ-021 Fill latency: grant sampled at edge N -> issues in cycles N+1..N+8, data N+5..N+12, done in N+12, IDLE at N+13 (12 cycles request-to-done).
REQ-022 mem_valid while IDLE or WRITE SHALL be ignored (no fill_we, no counter change).
REQ-023 Requests arriving during a non-IDLE state SHALL wait; no preemption of an active fill or write.
REQ-024 Counters SHALL be 4 bits (0..8), never wrap within a fill, cleared on grant.
REQ-025 mem_wr, mem_wdata SHALL be 0 outside WRITE; mem_addr SHALL be 0 when mem_en=0.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, clear counters and base; all outputs 0 the following cycle.
REQ-027 Reset mid-fill SHALL abandon the fill: no done pulse, late mem_valid ignored per REQ-022.

Structure
REQ-028 State enum, BLOCK_WORDS=8, BLOCK_MASK=16'hFFF0, MEM_LAT=4 SHALL live in shared package cache_pkg.
REQ-029 Issue/receive counting SHALL be one sub-module fill_counter, instantiated twice.

Verification
REQ-030 i_miss=1, addr 0x1234 -> reads 0x1230..0x123E in 8 cycles, 8 i_fill_we with fill_word 0..7, i_fill_done 12 cycles after grant.
REQ-031 d_wr_req, d_miss, i_miss together at one edge -> WRITE (d_wr_ack 1 cycle), then FILL_D to completion, then FILL_I.
REQ-032 d_miss raised at fill cycle 3 of FILL_I -> no effect until i_fill_done; FILL_D granted in the next IDLE cycle.
REQ-033 rst=1 at fill cycle 6 -> IDLE next cycle, no done, remaining mem_valid pulses produce no fill_we.
REQ-034 Spurious mem_valid in IDLE -> all fill outputs stay 0, busy=0.
